// File: rtl/srcnn_arith_pkg.sv
// Shared arithmetic definitions for the SRCNN datapath cores: divider FSM
// state encoding and a constant-evaluable ceil(log2) helper.
package srcnn_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // ceil(log2(v)); usable in localparam expressions
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/srcnn_sdiv_10s_10ns_10_seq_if.sv
// Operand/result bundle of the sequential signed divider.
// Handshake: ap_start is sampled only while ap_idle=1; ap_ready pulses in the
// cycle the operands are taken (din0/din1 may change after it); ap_done pulses
// for one cycle when dout/rem/div_by_zero are valid; they hold until the next ap_done.
interface srcnn_sdiv_10s_10ns_10_seq_if #(
    parameter int din0_WIDTH = 10,
    parameter int din1_WIDTH = 10,
    parameter int dout_WIDTH = 10
);
    logic                  ap_start;
    logic                  ap_ready;
    logic                  ap_idle;
    logic                  ap_done;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic [dout_WIDTH-1:0] dout;
    logic [din0_WIDTH-1:0] rem;
    logic                  div_by_zero;

    modport master (
        output ap_start, din0, din1,
        input  ap_ready, ap_idle, ap_done, dout, rem, div_by_zero
    );

    modport slave (
        input  ap_start, din0, din1,
        output ap_ready, ap_idle, ap_done, dout, rem, div_by_zero
    );
endinterface

// File: rtl/srcnn_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it does not borrow.
module srcnn_div_step #(
    parameter int DIVISOR_W = 10
) (
    input  logic [DIVISOR_W:0]   rem_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [DIVISOR_W:0]   rem_o,
    output logic                 qbit_o
);
    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W+1:0] diff;

    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {2'b00, divisor_i};
        // Borrow shows up as the sign bit of the widened difference
        qbit_o  = ~diff[DIVISOR_W+1];
        rem_o   = qbit_o ? diff[DIVISOR_W:0] : shifted[DIVISOR_W:0];
    end
endmodule

// File: rtl/srcnn_sdiv_10s_10ns_10_seq.sv
// Sequential signed/unsigned restoring divider, one quotient bit per cycle,
// with start/ready/idle/done control and divide-by-zero reporting.
module srcnn_sdiv_10s_10ns_10_seq
    import srcnn_arith_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 10,
    parameter int din1_WIDTH = 10,
    parameter int dout_WIDTH = 10
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    srcnn_sdiv_10s_10ns_10_seq_if.slave   bus,
    output state_t                        state_dbg
);
    localparam int W  = din0_WIDTH;
    localparam int D1 = din1_WIDTH;
    localparam int DW = dout_WIDTH;
    localparam int CW = int'(clog2(W + 1));
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);
    localparam logic [W-1:0]  ZERO_W   = '0;
    localparam logic [DW-1:0] ZERO_DW  = '0;
    localparam logic [31:0]   ID_VEC   = 32'(ID);

    wire unused_id = ^ID_VEC;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sign_q, sign_d;
    logic [W-1:0]  dvd_q, dvd_d;      // dividend magnitude, becomes quotient
    logic [D1-1:0] dvs_q, dvs_d;
    logic [D1:0]   prem_q, prem_d;
    logic          done_q, done_d;
    logic          idle_q, idle_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [W-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;

    logic [D1:0]   step_rem;
    logic          step_q;
    logic [W-1:0]  q_full;
    logic [DW-1:0] q_ext;
    logic [W-1:0]  r_trunc;

    srcnn_div_step #(.DIVISOR_W(D1)) u_step (
        .rem_i     (prem_q),
        .bit_i     (dvd_q[W-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .qbit_o    (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        dout_d  = dout_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        q_full  = {dvd_q[W-2:0], step_q};
        q_ext   = DW'(q_full);
        r_trunc = W'(step_rem);

        case (state_q)
            IDLE: begin
                if (bus.ap_start) begin
                    sign_d = bus.din0[W-1];
                    dvd_d  = bus.din0[W-1] ? (ZERO_W - bus.din0) : bus.din0;
                    dvs_d  = bus.din1;
                    prem_d = '0;
                    cnt_d  = '0;
                    if (bus.din1 == '0) begin
                        // Nothing to iterate: report straight away
                        state_d = DONE;
                        dout_d  = '0;
                        rem_d   = bus.din0;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                prem_d = step_rem;
                dvd_d  = q_full;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    dout_d  = sign_q ? (ZERO_DW - q_ext) : q_ext;
                    rem_d   = sign_q ? (ZERO_W - r_trunc) : r_trunc;
                    dbz_d   = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        idle_d = (state_d == IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            done_q  <= 1'b0;
            idle_q  <= 1'b1;
            dout_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            done_q  <= done_d;
            idle_q  <= idle_d;
            dout_q  <= dout_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // ready has to coincide with the capturing edge, so it is decoded from start
    assign bus.ap_ready    = idle_q & bus.ap_start;
    assign bus.ap_idle     = idle_q;
    assign bus.ap_done     = done_q;
    assign bus.dout        = dout_q;
    assign bus.rem         = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign state_dbg       = state_q;
endmodule
